// File: rtl/alu_ex_stage.sv
// -----------------------------------------------------------------------------
// alu_ex_stage
//   MiniMIPS execute stage. This is a two-register pipeline around the 32-bit
//   ALU datapath (AND/OR/XOR/NOR/ADD/SUB/SLT/SLTU).
//   - S1 holds the decoded op and its operands as accepted from ID.
//   - S2 holds the computed result, its flags and the destination register.
//   Both ends use valid/ready handshakes, so a stall in WB back-pressures ID.
//   No op is lost or duplicated during a stall.
//
// Ports
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset (drops ops in flight)
//   in_valid   in   1       ID presents a valid op
//   in_ready   out  1       stage accepts an op this cycle
//   alu_op     in   3       000 AND, 001 OR, 010 XOR, 011 NOR,
//                           100 ADD, 101 SUB, 110 SLT, 111 SLTU
//   value1     in   WIDTH   operand A (rs)
//   value2     in   WIDTH   operand B (rt/imm)
//   rd_in      in   REG_AW  destination register
//   out_valid  out  1       result valid toward WB
//   out_ready  in   1       WB takes the result this cycle
//   result     out  WIDTH   ALU result
//   zero       out  1       result == 0
//   ovf        out  1       signed overflow (ADD/SUB only)
//   rd_out     out  REG_AW  destination register carried with the result
// -----------------------------------------------------------------------------
module alu_ex_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [WIDTH-1:0]  value1,
  input  logic [WIDTH-1:0]  value2,
  input  logic [REG_AW-1:0] rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              ovf,
  output logic [REG_AW-1:0] rd_out
);

  // S1 state: the accepted op and its operands.
  logic              s1_valid_r;
  logic [2:0]        s1_op_r;
  logic [WIDTH-1:0]  s1_a_r;
  logic [WIDTH-1:0]  s1_b_r;
  logic [REG_AW-1:0] s1_rd_r;

  // S2 state: the result as presented to WB.
  logic              s2_valid_r;
  logic [WIDTH-1:0]  s2_result_r;
  logic              s2_zero_r;
  logic              s2_ovf_r;
  logic [REG_AW-1:0] s2_rd_r;

  // Handshake and ALU combinational signals.
  logic              s2_adv_s;
  logic              s1_load_s;
  logic              in_ready_s;
  logic [WIDTH-1:0]  sum_s;
  logic [WIDTH-1:0]  diff_s;
  logic [WIDTH-1:0]  alu_res_s;
  logic              alu_ovf_s;
  logic              alu_zero_s;

  // The S1 op moves to S2 when S2 is empty or is being drained this cycle.
  // in_ready depends on out_ready through s2_adv_s, but never on in_valid.
  assign s2_adv_s   = s1_valid_r && (!s2_valid_r || out_ready);
  assign in_ready_s = !s1_valid_r || s2_adv_s;
  assign s1_load_s  = in_valid && in_ready_s;
  assign in_ready   = in_ready_s;

  assign sum_s  = s1_a_r + s1_b_r;
  assign diff_s = s1_a_r - s1_b_r;

  // ALU datapath operating on the S1 operands.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (s1_op_r)
      3'b000: begin
        alu_res_s = s1_a_r & s1_b_r;
        alu_ovf_s = 1'b0;
      end
      3'b001: begin
        alu_res_s = s1_a_r | s1_b_r;
        alu_ovf_s = 1'b0;
      end
      3'b010: begin
        alu_res_s = s1_a_r ^ s1_b_r;
        alu_ovf_s = 1'b0;
      end
      3'b011: begin
        alu_res_s = ~(s1_a_r | s1_b_r);
        alu_ovf_s = 1'b0;
      end
      3'b100: begin
        // Overflow occurs when both operands share a sign that the sum does not.
        alu_res_s = sum_s;
        alu_ovf_s = (s1_a_r[WIDTH-1] == s1_b_r[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != s1_a_r[WIDTH-1]);
      end
      3'b101: begin
        // Overflow occurs when the operand signs differ and the result sign
        // differs from A.
        alu_res_s = diff_s;
        alu_ovf_s = (s1_a_r[WIDTH-1] != s1_b_r[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != s1_a_r[WIDTH-1]);
      end
      3'b110: begin
        alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(s1_a_r) < $signed(s1_b_r))};
        alu_ovf_s = 1'b0;
      end
      3'b111: begin
        alu_res_s = {{(WIDTH-1){1'b0}}, (s1_a_r < s1_b_r)};
        alu_ovf_s = 1'b0;
      end
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  assign alu_zero_s = (alu_res_s == {WIDTH{1'b0}});

  // S1 register: capture the op on an input handshake, and empty it once the op moves on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 3'b000;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_rd_r    <= {REG_AW{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= alu_op;
      s1_a_r     <= value1;
      s1_b_r     <= value2;
      s1_rd_r    <= rd_in;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S2 register: capture the ALU result on advance, and clear once WB takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= {WIDTH{1'b0}};
      s2_zero_r   <= 1'b0;
      s2_ovf_r    <= 1'b0;
      s2_rd_r     <= {REG_AW{1'b0}};
    end else if (s2_adv_s) begin
      s2_valid_r  <= 1'b1;
      s2_result_r <= alu_res_s;
      s2_zero_r   <= alu_zero_s;
      s2_ovf_r    <= alu_ovf_s;
      s2_rd_r     <= s1_rd_r;
    end else if (out_ready && s2_valid_r) begin
      s2_valid_r  <= 1'b0;
    end else begin
      s2_valid_r  <= s2_valid_r;
    end
  end

  assign out_valid = s2_valid_r;
  assign result    = s2_result_r;
  assign zero      = s2_zero_r;
  assign ovf       = s2_ovf_r;
  assign rd_out    = s2_rd_r;

endmodule

// File: tb/tb_alu_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_ex_stage
//   Scoreboard bench for alu_ex_stage. The stimulus pushes a hand-computed
//   expected response when an input handshake takes place. A separate monitor
//   pops from the scoreboard and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_alu_ex_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [31:0] value1;
  logic [31:0] value2;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic [4:0]  rd;
    int          exp_cyc;   // cycle the result must appear in, -1 = unchecked
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  alu_ex_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .value1(value1), .value2(value2), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every output transfer against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("zero", {31'd0, zero}, {31'd0, e.z});
        chk("ovf", {31'd0, ovf}, {31'd0, e.o});
        chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        if (e.exp_cyc >= 0) chk("latency", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  // Present one op and wait, with a bound, for its handshake.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] er, input logic ez,
                      input logic eo, input bit push, input bit timed);
    bit got;
    exp_t e;
    got = 1'b0;
    alu_op = op; value1 = a; value2 = b; rd_in = rd; in_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        if (push) begin
          e.res = er; e.z = ez; e.o = eo; e.rd = rd;
          e.exp_cyc = timed ? cyc + 2 : -1;
          sb.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake_timeout: got in_ready 0 want 1 (op %0d)", op);
    end
    in_valid = 1'b0;
  endtask

  // Wait, with a bound, for every expected result to come out.
  task automatic drain();
    for (int k = 0; k < 30 && sb.size() != 0; k++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; alu_op = 3'b000; value1 = 32'd0; value2 = 32'd0;
    rd_in = 5'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: single XOR with checked latency.
    send(3'b010, 32'hF000F000, 32'h0F001000, 5'd1, 32'hFF00E000, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // 2: back-to-back XOR stream, one result per cycle.
    send(3'b010, 32'hFFFF0000, 32'h0000FFFF, 5'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    send(3'b010, 32'h0F0F0F0F, 32'h0A0A0A0A, 5'd3, 32'h05050505, 1'b0, 1'b0, 1'b1, 1'b1);
    send(3'b010, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd4, 32'h55555555, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // 3: WB stall. Two ops are accepted, the third is held off and the output holds still.
    out_ready = 1'b0;
    send(3'b100, 32'h00000001, 32'h00000002, 5'd5, 32'h00000003, 1'b0, 1'b0, 1'b1, 1'b0);
    send(3'b001, 32'hF0F00000, 32'h00000F0F, 5'd6, 32'hF0F00F0F, 1'b0, 1'b0, 1'b1, 1'b0);
    alu_op = 3'b000; value1 = 32'hFFFF0000; value2 = 32'h12345678; rd_in = 5'd7;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_result", result, 32'h00000003);
      chk("stall_rd_out", {27'd0, rd_out}, 32'd5);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'b000, 32'hFFFF0000, 32'h12345678, 5'd7, 32'h12340000, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // 4: arithmetic, overflow and compare corners.
    send(3'b100, 32'h7FFFFFFF, 32'h00000001, 5'd8,  32'h80000000, 1'b0, 1'b1, 1'b1, 1'b1);
    send(3'b101, 32'h00000000, 32'h00000001, 5'd9,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    send(3'b110, 32'hFFFFFFFF, 32'h00000001, 5'd10, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1);
    send(3'b111, 32'hFFFFFFFF, 32'h00000001, 5'd11, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
    send(3'b101, 32'h80000000, 32'h00000001, 5'd12, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1);
    send(3'b100, 32'hFFFFFFFF, 32'h00000001, 5'd13, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
    // 5: zero flag.
    send(3'b010, 32'h12345678, 32'h12345678, 5'd14, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
    send(3'b011, 32'h00000000, 32'h00000000, 5'd15, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // 6: asynchronous reset with two ops in flight. Both are dropped.
    out_ready = 1'b0;
    send(3'b100, 32'h00000010, 32'h00000020, 5'd16, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0);
    send(3'b100, 32'h00000040, 32'h00000050, 5'd17, 32'h00000090, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_reset_result", result, 32'h00000030);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(3'b001, 32'h0000000A, 32'h00000005, 5'd18, 32'h0000000F, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
